rhs_miso_packetizer: RTL
========================

Name: rhs_miso_packetizer

Overview:
- Sits directly downstream of the RHS SPI command/stim engine.
- Consumes the 32-bit MISO words that engine captures each SPI transaction, one word per channel per frame.
- Frames them with the 64-bit Intan magic number and batches packet_len frames per AXI-Stream packet for the DMA.
- Absorbs downstream backpressure in a frame-commit FIFO, so the non-stallable SPI side never waits.

Parameters:
- NUM_CH, 32, data words per frame (channels across MISO1/MISO2).
- FIFO_DEPTH, 256, FIFO depth in 32-bit words; power of two, ≥ 2*NUM_CH.
- MAGIC, 64'hD7A22AAA38132A53, frame header value.

Ports:
- aclk  in  1  clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable (control register bit).
- packet_len  in  16  frames per packet; 0 is treated as 1.
- s_valid  in  1  one-cycle strobe: MISO word valid; no backpressure.
- s_first  in  1  qualifies s_valid: word is channel 0 of a frame.
- s_data  in  32  MISO word.
- m_axis_tdata  out  32  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of packet.
- drop_cnt  out  16  saturating count of dropped frames.
- frame_cnt  out  32  wrapping count of frames emitted.

Behaviour:
- Clock and reset: one clock, aclk; reset is areset, asynchronous and active-high. While areset is high:
  - m_axis_tvalid, m_axis_tlast, m_axis_tdata, drop_cnt and frame_cnt are 0 immediately.
  - FIFO pointers and all FSMs are cleared.
  - Reset mid-packet discards all buffered data; no tlast is emitted.
- Writer FSM, states IDLE / FILL / SKIP:
  - IDLE: on s_valid&&s_first&&enable:
    - If free space (relative to the committed read pointer) is ≥ NUM_CH, write the word and go to FILL with word count 1.
    - Otherwise increment drop_cnt and go to SKIP.
  - IDLE: s_valid without s_first is ignored.
  - FILL: each s_valid without s_first writes at the speculative pointer. When the count reaches NUM_CH, advance the commit pointer (the frame becomes visible to the reader the next cycle) and return to IDLE.
  - FILL, short frame: s_valid&&s_first before NUM_CH words roll the speculative pointer back to the commit pointer and increment drop_cnt. The new word is then treated as IDLE would treat it, in the same cycle.
  - SKIP: ignores words until the next s_first, which is handled as in IDLE.
  - enable low in IDLE: no new frame starts. A frame already in FILL completes normally.
- Reader FSM, states IDLE / HDR_LO / HDR_HI / DATA:
  - IDLE → HDR_LO when at least NUM_CH committed words are present. packet_len is latched (0→1) at the first frame of each packet.
  - HDR_LO emits MAGIC[31:0]; HDR_HI emits MAGIC[63:32]; DATA then emits NUM_CH FIFO words in order.
  - Each state advances only on tvalid&&tready. tdata and tvalid hold stable while tready is low. The FIFO read is prefetched, so there are no bubbles between words while tready stays high.
  - After the last DATA word: frame_cnt increments, batch count increments, then go to HDR_LO if another committed frame is present, else IDLE.
  - Latency: first header word is valid 2 cycles after commit with the reader idle.
- tlast rules:
  - tlast=1 on the last DATA word when batch count == latched packet_len−1.
  - Also tlast=1 there when enable is low and no further committed frame exists; this flushes a partial packet.
  - Batch count clears after any tlast.
- Widths and counters:
  - FIFO pointers carry one extra wrap bit; full/empty comparisons use it.
  - drop_cnt saturates at 16'hFFFF; frame_cnt wraps.
- Simultaneous events: a commit and a read in the same cycle are both honoured; the free-space check uses the pre-cycle read pointer, which is conservative.

Decomposition:
- Shared package rhs_pkg:
  - constants RHS_MAGIC and RHS_NUM_CH;
  - writer and reader state enums.
- Sub-module rhs_frame_fifo:
  - dual-pointer RAM FIFO with speculative write pointer, commit and rollback inputs, committed-count and free-count outputs;
  - single clock, asynchronous active-high reset.

Test Plan:
- Frame with tready=1: packet_len=1, 32 words 0x100+i (s_first on i=0) → 34 beats: 0x38132A53, 0xD7A22AAA, 0x100..0x11F; tlast only on 0x11F; frame_cnt=1.
- Batching: packet_len=4, 8 frames → 2 packets of 136 beats each, tlast at beats 136 and 272; packet_len=0 behaves as 1.
- Backpressure: tready toggles randomly → output sequence identical to the tready=1 case; tdata is stable whenever tvalid&&!tready.
- Overflow/short frame: hold tready=0 until FIFO is full; the next frame is dropped (drop_cnt=1). A 10-word frame followed by s_first increments drop_cnt, and none of its words appear.
- Flush: packet_len=4, 2 frames, then enable=0 → tlast on beat 68; no further output.
- Reset mid-packet: assert areset at beat 20 → tvalid=0 the same cycle; after release the next frame starts with a header and frame_cnt=0.

Source files
------------

// File: rtl/rhs_pkg.sv
// Shared constants, state encodings and helpers for the RHS MISO packetizer.
package rhs_pkg;

  localparam logic [63:0] RHS_MAGIC      = 64'hD7A2_2AAA_3813_2A53;
  localparam int          RHS_NUM_CH     = 32;
  localparam int          RHS_FIFO_DEPTH = 256;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_SKIP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_HDR_LO = 2'd1,
    R_HDR_HI = 2'd2,
    R_DATA   = 2'd3
  } rd_state_e;

  // A zero packet length means one frame per packet.
  function automatic logic [15:0] eff_packet_len(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/rhs_frame_fifo.sv
// Frame-commit FIFO: words land at a speculative pointer and only become
// readable once the whole frame is committed; a partial frame can be rolled back.
module rhs_frame_fifo #(
  parameter int DEPTH = 256,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   committed_count,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_spec_r;
  logic [AW:0]  wr_commit_r;
  logic [AW:0]  rd_ptr_r;
  logic [AW:0]  wr_base_s;
  logic [AW:0]  wr_spec_nx_s;

  // Rollback rewinds to the commit point before any same-cycle write lands.
  always_comb begin
    wr_base_s    = rollback ? wr_commit_r : wr_spec_r;
    wr_spec_nx_s = wr_en ? (wr_base_s + (AW+1)'(1)) : wr_base_s;
  end

  // Pointer registers; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_spec_r   <= '0;
      wr_commit_r <= '0;
      rd_ptr_r    <= '0;
    end else begin
      wr_spec_r <= wr_spec_nx_s;
      if (commit) begin
        wr_commit_r <= wr_spec_nx_s;
      end
      if (rd_en) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage array, written at the (possibly rewound) speculative pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_base_s[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data         = mem_r[rd_ptr_r[AW-1:0]];
  assign committed_count = wr_commit_r - rd_ptr_r;
  assign free_count      = (AW+1)'(DEPTH) - committed_count;

endmodule

// File: rtl/rhs_miso_packetizer.sv
// Frames per-channel MISO words with the Intan magic header and batches them
// into AXI-Stream packets, buffering whole frames against downstream stalls.
module rhs_miso_packetizer
  import rhs_pkg::*;
#(
  parameter int          NUM_CH     = RHS_NUM_CH,
  parameter int          FIFO_DEPTH = RHS_FIFO_DEPTH,
  parameter logic [63:0] MAGIC      = RHS_MAGIC
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [15:0] packet_len,
  input  logic        s_valid,
  input  logic        s_first,
  input  logic [31:0] s_data,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] drop_cnt,
  output logic [31:0] frame_cnt
);

  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            CW         = $clog2(NUM_CH + 1);
  localparam logic [AW:0]   NUM_CH_P   = (AW+1)'(NUM_CH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(NUM_CH - 2);

  logic [31:0]   rd_data_s;
  logic [AW:0]   committed_s;
  logic [AW:0]   free_s;

  wr_state_e     wr_state_r, wr_state_nx_s, st_state_s;
  logic [CW-1:0] wcnt_r, wcnt_nx_s;
  logic          wr_en_s, commit_s, rollback_s, st_write_s, st_drop_s;
  logic [1:0]    drop_add_s;
  logic [15:0]   drop_cnt_r;
  logic [16:0]   drop_sum_s;

  rd_state_e     rd_state_r, rd_state_nx_s;
  logic [CW-1:0] didx_r, didx_nx_s;
  logic [15:0]   batch_r, batch_nx_s, plen_r, plen_nx_s;
  logic [31:0]   tdata_r, tdata_nx_s, frame_cnt_r;
  logic          tvalid_r, tvalid_nx_s, tlast_r, tlast_nx_s;
  logic          rd_en_s, frame_inc_s, hdr_start_s, ld_s;
  logic          have_frame_s, more_frame_s, tlast_cand_s;

  rhs_frame_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk             (aclk),
    .rst             (areset),
    .wr_en           (wr_en_s),
    .wr_data         (s_data),
    .commit          (commit_s),
    .rollback        (rollback_s),
    .rd_en           (rd_en_s),
    .rd_data         (rd_data_s),
    .committed_count (committed_s),
    .free_count      (free_s)
  );

  // Outcome of a frame start (s_first), shared by every writer state.
  always_comb begin
    if (!enable) begin
      st_state_s = W_IDLE;
      st_write_s = 1'b0;
      st_drop_s  = 1'b0;
    end else if (free_s >= NUM_CH_P) begin
      st_state_s = W_FILL;
      st_write_s = 1'b1;
      st_drop_s  = 1'b0;
    end else begin
      st_state_s = W_SKIP;
      st_write_s = 1'b0;
      st_drop_s  = 1'b1;
    end
  end

  // Writer next-state: fill, commit, roll back short frames, skip dropped ones.
  always_comb begin
    wr_state_nx_s = wr_state_r;
    wcnt_nx_s     = wcnt_r;
    wr_en_s       = 1'b0;
    commit_s      = 1'b0;
    rollback_s    = 1'b0;
    drop_add_s    = 2'd0;
    case (wr_state_r)
      W_IDLE, W_SKIP: begin
        if (s_valid && s_first) begin
          wr_state_nx_s = st_state_s;
          wr_en_s       = st_write_s;
          wcnt_nx_s     = st_write_s ? CW'(1) : CW'(0);
          drop_add_s    = {1'b0, st_drop_s};
        end else begin
          wr_state_nx_s = wr_state_r;
        end
      end
      W_FILL: begin
        if (s_valid && s_first) begin
          rollback_s    = 1'b1;
          wr_state_nx_s = st_state_s;
          wr_en_s       = st_write_s;
          wcnt_nx_s     = st_write_s ? CW'(1) : CW'(0);
          drop_add_s    = 2'd1 + {1'b0, st_drop_s};
        end else if (s_valid) begin
          wr_en_s = 1'b1;
          if (wcnt_r == LAST_IDX) begin
            commit_s      = 1'b1;
            wr_state_nx_s = W_IDLE;
            wcnt_nx_s     = CW'(0);
          end else begin
            wcnt_nx_s = wcnt_r + CW'(1);
          end
        end else begin
          wr_state_nx_s = W_FILL;
        end
      end
      default: wr_state_nx_s = W_IDLE;
    endcase
  end

  assign drop_sum_s = {1'b0, drop_cnt_r} + 17'(drop_add_s);

  // Writer registers and saturating drop counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_r <= W_IDLE;
      wcnt_r     <= '0;
      drop_cnt_r <= 16'd0;
    end else begin
      wr_state_r <= wr_state_nx_s;
      wcnt_r     <= wcnt_nx_s;
      drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
  end

  // The output register reloads whenever it is empty or being accepted.
  assign ld_s         = !tvalid_r || m_axis_tready;
  assign have_frame_s = committed_s >= NUM_CH_P;
  assign more_frame_s = committed_s > NUM_CH_P;
  assign tlast_cand_s = (batch_r == plen_r - 16'd1) || (!enable && !more_frame_s);

  // Reader next-state: the state names the word currently held in the output register.
  always_comb begin
    rd_state_nx_s = rd_state_r;
    didx_nx_s     = didx_r;
    batch_nx_s    = batch_r;
    plen_nx_s     = plen_r;
    tdata_nx_s    = tdata_r;
    tvalid_nx_s   = tvalid_r;
    tlast_nx_s    = tlast_r;
    rd_en_s       = 1'b0;
    frame_inc_s   = 1'b0;
    hdr_start_s   = 1'b0;
    case (rd_state_r)
      R_IDLE: hdr_start_s = have_frame_s;
      R_HDR_LO: begin
        if (ld_s) begin
          tdata_nx_s    = MAGIC[63:32];
          rd_state_nx_s = R_HDR_HI;
        end else begin
          rd_state_nx_s = R_HDR_LO;
        end
      end
      R_HDR_HI: begin
        if (ld_s) begin
          tdata_nx_s    = rd_data_s;
          rd_en_s       = 1'b1;
          didx_nx_s     = CW'(0);
          rd_state_nx_s = R_DATA;
        end else begin
          rd_state_nx_s = R_HDR_HI;
        end
      end
      R_DATA: begin
        if (ld_s && (didx_r == LAST_IDX)) begin
          frame_inc_s = 1'b1;
          batch_nx_s  = tlast_r ? 16'd0 : (batch_r + 16'd1);
          if (have_frame_s) begin
            hdr_start_s = 1'b1;
          end else begin
            rd_state_nx_s = R_IDLE;
            tvalid_nx_s   = 1'b0;
            tlast_nx_s    = 1'b0;
            tdata_nx_s    = 32'd0;
          end
        end else if (ld_s) begin
          tdata_nx_s = rd_data_s;
          rd_en_s    = 1'b1;
          didx_nx_s  = didx_r + CW'(1);
          tlast_nx_s = (didx_r == PENULT_IDX) && tlast_cand_s;
        end else begin
          rd_state_nx_s = R_DATA;
        end
      end
      default: rd_state_nx_s = R_IDLE;
    endcase
    if (hdr_start_s) begin
      rd_state_nx_s = R_HDR_LO;
      tdata_nx_s    = MAGIC[31:0];
      tvalid_nx_s   = 1'b1;
      tlast_nx_s    = 1'b0;
      plen_nx_s     = (batch_nx_s == 16'd0) ? eff_packet_len(packet_len) : plen_r;
    end else begin
      plen_nx_s = plen_r;
    end
  end

  // Reader registers, including the registered stream outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_r  <= R_IDLE;
      didx_r      <= '0;
      batch_r     <= 16'd0;
      plen_r      <= 16'd1;
      tdata_r     <= 32'd0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      frame_cnt_r <= 32'd0;
    end else begin
      rd_state_r  <= rd_state_nx_s;
      didx_r      <= didx_nx_s;
      batch_r     <= batch_nx_s;
      plen_r      <= plen_nx_s;
      tdata_r     <= tdata_nx_s;
      tvalid_r    <= tvalid_nx_s;
      tlast_r     <= tlast_nx_s;
      frame_cnt_r <= frame_cnt_r + {31'd0, frame_inc_s};
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign drop_cnt      = drop_cnt_r;
  assign frame_cnt     = frame_cnt_r;

endmodule
